// File: rtl/hm_sync_pkg.sv
// ============================================================================
// Module  : hm_sync_pkg
// Brief   : Shared FSM state encoding and parameter defaults for hm_sync_bank.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hm_sync_pkg;

    localparam int NCH_DEFAULT         = 8;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int DW_DEFAULT          = 32;
    localparam int CW_DEFAULT          = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/hm_sync_tgl.sv
// ============================================================================
// Module  : hm_sync_tgl
// Brief   : Toggle synchroniser chain followed by a one-flop edge detector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hm_sync_tgl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tgl,
    output logic evt
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], tgl};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    // Any level change at the chain output is one foreign-domain event.
    assign evt = sync[SYNC_STAGES-1] ^ prev;

endmodule

`default_nettype wire

// File: rtl/hm_sync_bank.sv
// ============================================================================
// Module  : hm_sync_bank
// Brief   : Bank of toggle-event synchronisers with optional saturating
//           counters, plus a req/ack toggle handshake for a bundled data word.
//           Counters are built only when HM_SYNC_COUNTERS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hm_sync_bank
    import hm_sync_pkg::*;
#(
    parameter int NCH         = NCH_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int DW          = DW_DEFAULT,
    parameter int CW          = CW_DEFAULT
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [NCH-1:0]    async_evt_tgl,
    output logic [NCH-1:0]    evt_pulse,
    output logic [NCH*CW-1:0] evt_cnt,
    input  logic [NCH-1:0]    evt_cnt_clr,
    input  logic              async_req_tgl,
    input  logic [DW-1:0]     async_data,
    output logic              ack_tgl,
    output logic              data_valid,
    output logic [DW-1:0]     data,
    input  logic              data_ready
);

    localparam int PCW = $clog2(SYNC_STAGES + 1);

    logic [NCH-1:0] evt_edge;
    logic           req_edge;
    logic           req_go;
    logic [PCW-1:0] prime_cnt;
    logic           primed;
    state_t         state;
    state_t         state_nxt;
    logic           capture;
    logic           ack_flip;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_evt
            hm_sync_tgl #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_tgl (
                .clk   (sys_clk),
                .rst_n (sys_rst_n),
                .tgl   (async_evt_tgl[i]),
                .evt   (evt_edge[i])
            );
        end
    endgenerate

    hm_sync_tgl #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .tgl   (async_req_tgl),
        .evt   (req_edge)
    );

    // Chains come out of reset at 0; edges seen before they fill with real
    // input levels are artefacts of reset, not events, so they are masked.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prime_cnt <= '0;
            primed    <= 1'b0;
        end else if (!primed) begin
            if (prime_cnt == PCW'(SYNC_STAGES)) begin
                primed <= 1'b1;
            end else begin
                prime_cnt <= prime_cnt + PCW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            evt_pulse <= '0;
        end else begin
            evt_pulse <= evt_edge & {NCH{primed}};
        end
    end

    assign req_go = req_edge & primed;

`ifdef HM_SYNC_COUNTERS_EN
    generate
        for (genvar i = 0; i < NCH; i++) begin : g_cnt
            logic [CW-1:0] cnt;

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    cnt <= '0;
                end else if (evt_cnt_clr[i]) begin
                    cnt <= evt_pulse[i] ? CW'(1) : '0;
                end else if (evt_pulse[i] && (cnt != {CW{1'b1}})) begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign evt_cnt[i*CW +: CW] = cnt;
        end
    endgenerate
`else
    logic unused_cnt_clr;

    assign evt_cnt        = '0;
    assign unused_cnt_clr = ^evt_cnt_clr;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= ST_IDLE;
            data    <= '0;
            ack_tgl <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                data <= async_data;
            end
            if (ack_flip) begin
                ack_tgl <= ~ack_tgl;
            end
        end
    end

    // Req edges outside IDLE fall through untouched: the sender broke protocol.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        ack_flip  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_go) begin
                    state_nxt = ST_CAPT;
                end
            end
            ST_CAPT: begin
                capture   = 1'b1;
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (data_ready) begin
                    ack_flip  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign data_valid = (state == ST_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_hm_sync_bank.sv
// ============================================================================
// Module  : tb_hm_sync_bank
// Brief   : Directed self-checking bench for hm_sync_bank (default parameters).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hm_sync_bank;

`ifdef HM_SYNC_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  async_evt_tgl = '0;
    logic [7:0]  evt_pulse;
    logic [63:0] evt_cnt;
    logic [7:0]  evt_cnt_clr = '0;
    logic        async_req_tgl = 1'b0;
    logic [31:0] async_data = '0;
    logic        ack_tgl;
    logic        data_valid;
    logic [31:0] data;
    logic        data_ready = 1'b0;

    int errs   = 0;
    int checks = 0;
    bit exp_ack = 1'b0;

    hm_sync_bank dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .async_evt_tgl (async_evt_tgl),
        .evt_pulse     (evt_pulse),
        .evt_cnt       (evt_cnt),
        .evt_cnt_clr   (evt_cnt_clr),
        .async_req_tgl (async_req_tgl),
        .async_data    (async_data),
        .ack_tgl       (ack_tgl),
        .data_valid    (data_valid),
        .data          (data),
        .data_ready    (data_ready)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    function automatic logic [7:0] cnt_of(input int ch);
        return evt_cnt[ch*8 +: 8];
    endfunction

    task automatic test_reset;
        sys_rst_n     = 1'b0;
        async_evt_tgl = 8'hFF;
        step(3);
        checks++; if (evt_pulse !== 8'h00) begin errs++; $display("FAIL rst_pulse: got %h want 00", evt_pulse); end
        checks++; if (evt_cnt !== 64'h0) begin errs++; $display("FAIL rst_cnt: got %h want 0", evt_cnt); end
        checks++; if (data_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", data_valid); end
        checks++; if (ack_tgl !== 1'b0) begin errs++; $display("FAIL rst_ack: got %b want 0", ack_tgl); end
        checks++; if (data !== 32'h0) begin errs++; $display("FAIL rst_data: got %h want 0", data); end
        sys_rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step(1);
            checks++; if (evt_pulse !== 8'h00) begin errs++; $display("FAIL prime_pulse c%0d: got %h want 00", c, evt_pulse); end
        end
        checks++; if (evt_cnt !== 64'h0) begin errs++; $display("FAIL prime_cnt: got %h want 0", evt_cnt); end
    endtask

    task automatic test_event;
        async_evt_tgl[3] = ~async_evt_tgl[3];
        step(1);
        checks++; if (evt_pulse !== 8'h00) begin errs++; $display("FAIL evt_c1: got %h want 00", evt_pulse); end
        step(1);
        checks++; if (evt_pulse !== 8'h00) begin errs++; $display("FAIL evt_c2: got %h want 00", evt_pulse); end
        step(1);
        checks++; if (evt_pulse !== 8'h08) begin errs++; $display("FAIL evt_c3: got %h want 08", evt_pulse); end
        step(1);
        checks++; if (evt_pulse !== 8'h00) begin errs++; $display("FAIL evt_c4: got %h want 00", evt_pulse); end
        checks++; if (cnt_of(3) !== (CNT_EN ? 8'd1 : 8'd0)) begin errs++; $display("FAIL evt_cnt3: got %0d want %0d", cnt_of(3), CNT_EN ? 1 : 0); end
    endtask

    task automatic test_multi;
        async_evt_tgl = async_evt_tgl ^ 8'hA1;
        step(3);
        checks++; if (evt_pulse !== 8'hA1) begin errs++; $display("FAIL multi_pulse: got %h want a1", evt_pulse); end
        step(1);
        checks++; if (evt_pulse !== 8'h00) begin errs++; $display("FAIL multi_end: got %h want 00", evt_pulse); end
        checks++; if (cnt_of(5) !== (CNT_EN ? 8'd1 : 8'd0)) begin errs++; $display("FAIL multi_cnt5: got %0d want %0d", cnt_of(5), CNT_EN ? 1 : 0); end
    endtask

    task automatic test_saturate;
        for (int k = 0; k < 300; k++) begin
            async_evt_tgl[0] = ~async_evt_tgl[0];
            step(2);
        end
        step(5);
        checks++; if (cnt_of(0) !== (CNT_EN ? 8'd255 : 8'd0)) begin errs++; $display("FAIL sat_cnt0: got %0d want %0d", cnt_of(0), CNT_EN ? 255 : 0); end
        checks++; if (cnt_of(3) !== (CNT_EN ? 8'd1 : 8'd0)) begin errs++; $display("FAIL sat_cnt3: got %0d want %0d", cnt_of(3), CNT_EN ? 1 : 0); end
    endtask

    task automatic test_clear;
        for (int k = 0; k < 5; k++) begin
            async_evt_tgl[1] = ~async_evt_tgl[1];
            step(2);
        end
        step(4);
        checks++; if (cnt_of(1) !== (CNT_EN ? 8'd5 : 8'd0)) begin errs++; $display("FAIL clr_pre: got %0d want %0d", cnt_of(1), CNT_EN ? 5 : 0); end
        async_evt_tgl[1] = ~async_evt_tgl[1];
        step(3);
        checks++; if (evt_pulse !== 8'h02) begin errs++; $display("FAIL clr_pulse: got %h want 02", evt_pulse); end
        evt_cnt_clr[1] = 1'b1;
        step(1);
        evt_cnt_clr = '0;
        checks++; if (cnt_of(1) !== (CNT_EN ? 8'd1 : 8'd0)) begin errs++; $display("FAIL clr_coinc: got %0d want %0d", cnt_of(1), CNT_EN ? 1 : 0); end
        evt_cnt_clr[1] = 1'b1;
        step(1);
        evt_cnt_clr = '0;
        checks++; if (cnt_of(1) !== 8'd0) begin errs++; $display("FAIL clr_alone: got %0d want 0", cnt_of(1)); end
        checks++; if (cnt_of(3) !== (CNT_EN ? 8'd1 : 8'd0)) begin errs++; $display("FAIL clr_other: got %0d want %0d", cnt_of(3), CNT_EN ? 1 : 0); end
    endtask

    task automatic test_data;
        data_ready    = 1'b0;
        async_data    = 32'hDEADBEEF;
        async_req_tgl = ~async_req_tgl;
        step(3);
        checks++; if (data_valid !== 1'b0) begin errs++; $display("FAIL data_early: got %b want 0", data_valid); end
        step(1);
        checks++; if (data_valid !== 1'b1) begin errs++; $display("FAIL data_valid: got %b want 1", data_valid); end
        checks++; if (data !== 32'hDEADBEEF) begin errs++; $display("FAIL data_word: got %h want deadbeef", data); end
        async_data = 32'h55555555;
        step(3);
        checks++; if (data !== 32'hDEADBEEF || data_valid !== 1'b1) begin errs++; $display("FAIL data_hold: got %h/%b want deadbeef/1", data, data_valid); end
        checks++; if (ack_tgl !== exp_ack) begin errs++; $display("FAIL data_noack: got %b want %b", ack_tgl, exp_ack); end
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;
        exp_ack    = ~exp_ack;
        checks++; if (ack_tgl !== exp_ack) begin errs++; $display("FAIL data_ack: got %b want %b", ack_tgl, exp_ack); end
        checks++; if (data_valid !== 1'b0) begin errs++; $display("FAIL data_drop: got %b want 0", data_valid); end
    endtask

    task automatic test_reset_mid;
        async_data    = 32'hCAFE0001;
        async_req_tgl = ~async_req_tgl;
        step(4);
        checks++; if (data_valid !== 1'b1) begin errs++; $display("FAIL mid_hold: got %b want 1", data_valid); end
        #2 sys_rst_n = 1'b0;
        #1;
        exp_ack = 1'b0;
        checks++; if (data_valid !== 1'b0) begin errs++; $display("FAIL mid_valid: got %b want 0", data_valid); end
        checks++; if (ack_tgl !== 1'b0) begin errs++; $display("FAIL mid_ack: got %b want 0", ack_tgl); end
        checks++; if (data !== 32'h0) begin errs++; $display("FAIL mid_data: got %h want 0", data); end
        step(1);
        sys_rst_n = 1'b1;
        step(6);
        checks++; if (data_valid !== 1'b0) begin errs++; $display("FAIL mid_spurious: got %b want 0", data_valid); end
        checks++; if (evt_pulse !== 8'h00) begin errs++; $display("FAIL mid_pulse: got %h want 00", evt_pulse); end
        async_data    = 32'hCAFE0002;
        async_req_tgl = ~async_req_tgl;
        step(4);
        checks++; if (data_valid !== 1'b1 || data !== 32'hCAFE0002) begin errs++; $display("FAIL mid_recap: got %b/%h want 1/cafe0002", data_valid, data); end
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;
        exp_ack    = ~exp_ack;
        checks++; if (ack_tgl !== exp_ack) begin errs++; $display("FAIL mid_ack2: got %b want %b", ack_tgl, exp_ack); end
    endtask

    task automatic test_violation;
        async_data    = 32'h12345678;
        async_req_tgl = ~async_req_tgl;
        step(4);
        checks++; if (data_valid !== 1'b1 || data !== 32'h12345678) begin errs++; $display("FAIL viol_cap: got %b/%h want 1/12345678", data_valid, data); end
        async_data    = 32'h0BADF00D;
        async_req_tgl = ~async_req_tgl;
        step(5);
        checks++; if (data_valid !== 1'b1 || data !== 32'h12345678) begin errs++; $display("FAIL viol_hold: got %b/%h want 1/12345678", data_valid, data); end
        checks++; if (ack_tgl !== exp_ack) begin errs++; $display("FAIL viol_noack: got %b want %b", ack_tgl, exp_ack); end
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;
        exp_ack    = ~exp_ack;
        checks++; if (ack_tgl !== exp_ack) begin errs++; $display("FAIL viol_ack: got %b want %b", ack_tgl, exp_ack); end
        step(5);
        checks++; if (data_valid !== 1'b0) begin errs++; $display("FAIL viol_ignored: got %b want 0", data_valid); end
        checks++; if (ack_tgl !== exp_ack) begin errs++; $display("FAIL viol_ack_stable: got %b want %b", ack_tgl, exp_ack); end
    endtask

    task automatic test_back_to_back;
        data_ready    = 1'b1;
        async_data    = 32'hA5A5A5A5;
        async_req_tgl = ~async_req_tgl;
        step(4);
        checks++; if (data_valid !== 1'b1 || data !== 32'hA5A5A5A5) begin errs++; $display("FAIL b2b_a: got %b/%h want 1/a5a5a5a5", data_valid, data); end
        step(1);
        exp_ack = ~exp_ack;
        checks++; if (data_valid !== 1'b0 || ack_tgl !== exp_ack) begin errs++; $display("FAIL b2b_a_ack: got %b/%b want 0/%b", data_valid, ack_tgl, exp_ack); end
        async_data    = 32'h5A5A5A5A;
        async_req_tgl = ~async_req_tgl;
        step(4);
        checks++; if (data_valid !== 1'b1 || data !== 32'h5A5A5A5A) begin errs++; $display("FAIL b2b_b: got %b/%h want 1/5a5a5a5a", data_valid, data); end
        step(1);
        exp_ack = ~exp_ack;
        checks++; if (data_valid !== 1'b0 || ack_tgl !== exp_ack) begin errs++; $display("FAIL b2b_b_ack: got %b/%b want 0/%b", data_valid, ack_tgl, exp_ack); end
        data_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_event;
        test_multi;
        test_saturate;
        test_clear;
        test_data;
        test_reset_mid;
        test_violation;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/hm_sync_bank.md
HM_SYNC_BANK -- requirements
Module: hm_sync_bank

Interface
REQ-001 Parameter NCH, default 8: number of toggle-encoded event channels, range 1-32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flop depth, range 2-4.
REQ-003 Parameter DW, default 32: bundled data word width.
REQ-004 Parameter CW, default 8: per-channel event counter width.
REQ-005 sys_clk  in  1  single block clock; all flops clocked on its rising edge.
REQ-006 sys_rst_n  in  1  asynchronous active-low reset.
REQ-007 async_evt_tgl  in  NCH  foreign-domain event toggles; each edge is one event.
REQ-008 evt_pulse  out  NCH  one-cycle pulse per detected event.
REQ-009 evt_cnt  out  NCH*CW  saturating per-channel event counts; channel i occupies bits [i*CW +: CW].
REQ-010 evt_cnt_clr  in  NCH  synchronous per-channel counter clear.
REQ-011 async_req_tgl  in  1  foreign-domain request toggle for bundled data.
REQ-012 async_data  in  DW  bundled data, held stable by the sender from the req edge until the matching ack edge.
REQ-013 ack_tgl  out  1  acknowledge toggle returned to the sender.
REQ-014 data_valid  out  1  captured word available.
REQ-015 data  out  DW  captured word.
REQ-016 data_ready  in  1  sys-side consumer accepts the word.

Function
REQ-017 Each async input SHALL pass through SYNC_STAGES flops, then a one-flop edge detector; evt_pulse[i] SHALL be high for exactly one cycle, SYNC_STAGES+1 cycles after the input edge.
REQ-018 Events on different channels in the same cycle SHALL each produce an independent pulse.
REQ-019 An event on channel i SHALL increment evt_cnt[i] by 1, saturating at 2^CW-1 with no wrap.
REQ-020 If evt_cnt_clr[i] and an event pulse coincide, evt_cnt[i] SHALL become 1.
REQ-021 If evt_cnt_clr[i] is high with no coincident pulse, evt_cnt[i] SHALL become 0.
REQ-022 The data FSM states are IDLE, CAPT and HOLD.
REQ-023 IDLE -> CAPT on a synchronised req edge; CAPT SHALL register async_data into data and go to HOLD.
REQ-024 In HOLD, data_valid SHALL be 1 and data SHALL be stable; on data_valid && data_ready, ack_tgl SHALL invert and the FSM SHALL return to IDLE in the same cycle.
REQ-025 data_valid SHALL first rise SYNC_STAGES+2 cycles after the async_req_tgl edge.
REQ-026 A req edge detected while in CAPT or HOLD is a protocol violation; it SHALL be ignored (no capture, no ack).
REQ-027 data_valid SHALL be 0 in IDLE and CAPT.

Reset
REQ-028 Reset SHALL clear all synchroniser flops, edge detectors, counters, data, data_valid and ack_tgl to 0, and force the FSM to IDLE.
REQ-029 A prime flag, cleared by reset, SHALL set SYNC_STAGES+1 cycles after reset release; while it is clear, evt_pulse SHALL stay 0 and req edges SHALL be ignored.
REQ-030 A reset asserted mid-transfer SHALL abort the transfer; the pending word SHALL be dropped and ack_tgl SHALL return to 0.

Configuration
REQ-031 With HM_SYNC_COUNTERS_EN defined, the counters and evt_cnt_clr SHALL behave per REQ-019 to REQ-021.
REQ-032 Without HM_SYNC_COUNTERS_EN, no counter flops SHALL be built, evt_cnt SHALL be constant 0 and evt_cnt_clr SHALL be ignored.

Structure
REQ-033 Package hm_sync_pkg SHALL hold the FSM state enum and the parameter default constants.
REQ-034 Sub-module hm_sync_tgl (synchroniser chain plus edge detector, parametrised by SYNC_STAGES) SHALL be instantiated NCH+1 times: one per event channel and one for the req toggle.

Verification
REQ-035 SYNC_STAGES=2, toggle async_evt_tgl[3] at cycle 10 -> evt_pulse[3] high only at cycle 13; evt_cnt[3]=1.
REQ-036 Toggle channel 0 three hundred times with CW=8 -> evt_cnt[0] holds 255.
REQ-037 Assert evt_cnt_clr[1] in the same cycle as evt_pulse[1] while evt_cnt[1]=5 -> evt_cnt[1]=1.
REQ-038 Set async_data=0xDEADBEEF and toggle async_req_tgl with data_ready=0 -> data_valid rises 4 cycles later and data holds 0xDEADBEEF; raise data_ready -> ack_tgl inverts and data_valid falls the next cycle.
REQ-039 Release reset with async_evt_tgl=all ones -> no evt_pulse during the prime window and all counters stay 0.
REQ-040 Assert sys_rst_n low in HOLD -> data_valid=0, ack_tgl=0, FSM=IDLE; a new req edge after priming is captured normally.
